// File: rtl/pulse_stretcher_pkg.sv
// Shared types and helpers for the pulse stretcher: FSM state encoding and
// a small constant helper used to size the tick counter.
package stretch_pkg;

    // FSM state encoding; the unused code 2'b11 is steered back to IDLE.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ON   = 2'b01,
        ST_OFF  = 2'b10
    } state_e;

    localparam logic [1:0] STATE_IDLE = 2'b00;
    localparam logic [1:0] STATE_ON   = 2'b01;
    localparam logic [1:0] STATE_OFF  = 2'b10;

    // Larger of two integers, for compile-time sizing.
    function automatic int max2(input int a, input int b);
        if (a > b) begin
            return a;
        end else begin
            return b;
        end
    endfunction

    // Width needed to count 0 .. max_ticks-1 (at least one bit).
    function automatic int tcnt_width(input int max_ticks);
        if (max_ticks > 2) begin
            return $clog2(max_ticks);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/pulse_stretcher_if.sv
// Event/status bundle between the game logic and the pulse stretcher.
// The master drives event pulses; the slave (the stretcher) reports status.
// The request pulse is named evt because "event" is a reserved word.
interface pulse_stretcher_if #(
    parameter int PEND_W = 3
);
    logic              evt;
    logic              out;
    logic              busy;
    logic [PEND_W-1:0] pending;
    logic              dropped;

    modport master (
        output evt,
        input  out,
        input  busy,
        input  pending,
        input  dropped
    );

    modport slave (
        input  evt,
        output out,
        output busy,
        output pending,
        output dropped
    );
endinterface

// File: rtl/pulse_stretcher_tick_prescaler.sv
// Free-running N-bit prescaler with synchronous clear. tick is high on the
// last count of every 2^N-cycle window, so clearing restarts a full window.
module tick_prescaler #(
    parameter int N = 17
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    logic [N-1:0] count_q;
    logic [N-1:0] count_d;

    // Next count: restart on clear, otherwise advance by one.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = {N{1'b0}};
        end else begin
            count_d = count_q + N'(1);
        end
    end

    // Prescaler register with synchronous active-high reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= {N{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign tick = &count_q;

endmodule

// File: rtl/pulse_stretcher.sv
// Pulse stretcher: turns single-cycle events into an output level with a
// guaranteed high time and low gap, both measured in prescaler ticks.
// Events arriving while busy are queued in a saturating counter and replayed.
module pulse_stretcher
    import stretch_pkg::*;
#(
    parameter int N         = 17,
    parameter int ON_TICKS  = 3,
    parameter int OFF_TICKS = 3,
    parameter int PEND_W    = 3
) (
    input logic               clock,
    input logic               reset,
    pulse_stretcher_if.slave  bus
);

    localparam int TCNT_W = tcnt_width(max2(ON_TICKS, OFF_TICKS));
    localparam logic [TCNT_W-1:0] ON_LAST  = TCNT_W'(ON_TICKS - 1);
    localparam logic [TCNT_W-1:0] OFF_LAST = TCNT_W'(OFF_TICKS - 1);
    localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};

    state_e              state_q;
    state_e              state_d;
    logic [TCNT_W-1:0]   tcnt_q;
    logic [TCNT_W-1:0]   tcnt_d;
    logic [PEND_W-1:0]   pending_q;
    logic [PEND_W-1:0]   pending_d;
    logic                out_q;
    logic                out_d;
    logic                busy_q;
    logic                busy_d;
    logic                dropped_q;
    logic                dropped_d;

    logic                tick_s;
    logic                presc_clear_s;
    logic                in_period_s;
    logic                pend_nz_s;
    logic                last_on_s;
    logic                last_off_s;
    logic                dec_s;
    logic                inc_s;

    tick_prescaler #(
        .N (N)
    ) u_presc (
        .clock (clock),
        .reset (reset),
        .clear (presc_clear_s),
        .tick  (tick_s)
    );

    // Decode of the current period: which state we are in and whether this
    // cycle is the final tick of the ON or OFF period.
    always_comb begin
        in_period_s = 1'b0;
        pend_nz_s   = 1'b0;
        last_on_s   = 1'b0;
        last_off_s  = 1'b0;
        in_period_s = (state_q == ST_ON) || (state_q == ST_OFF);
        pend_nz_s   = (pending_q != {PEND_W{1'b0}});
        last_on_s   = (state_q == ST_ON)  && tick_s && (tcnt_q == ON_LAST);
        last_off_s  = (state_q == ST_OFF) && tick_s && (tcnt_q == OFF_LAST);
    end

    // FSM next-state: IDLE starts on a fresh or queued event, ON runs its
    // ticks then drops to OFF, OFF either replays a queued event or idles.
    always_comb begin
        state_d = ST_IDLE;
        case (state_q)
            ST_IDLE: begin
                if (bus.evt || pend_nz_s) begin
                    state_d = ST_ON;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ON: begin
                if (last_on_s) begin
                    state_d = ST_OFF;
                end else begin
                    state_d = ST_ON;
                end
            end
            ST_OFF: begin
                if (last_off_s) begin
                    if (pend_nz_s) begin
                        state_d = ST_ON;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_OFF;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Pending queue: an event while a period runs (or while a queued replay
    // is about to start from IDLE) is queued; a replay consumes one entry.
    // Simultaneous queue and consume cancel; a full queue drops the event.
    always_comb begin
        dec_s     = 1'b0;
        inc_s     = 1'b0;
        pending_d = pending_q;
        dropped_d = 1'b0;
        dec_s = (last_off_s && pend_nz_s) || ((state_q == ST_IDLE) && pend_nz_s);
        inc_s = bus.evt && (in_period_s || pend_nz_s);
        if (inc_s && !dec_s) begin
            if (pending_q == PEND_MAX) begin
                pending_d = pending_q;
                dropped_d = 1'b1;
            end else begin
                pending_d = pending_q + PEND_W'(1);
            end
        end else if (dec_s && !inc_s) begin
            pending_d = pending_q - PEND_W'(1);
        end else begin
            pending_d = pending_q;
        end
    end

    // Period timing: restart prescaler and tick count on entry to ON/OFF,
    // count ticks while a period runs, and derive the registered outputs.
    always_comb begin
        presc_clear_s = 1'b0;
        tcnt_d        = tcnt_q;
        out_d         = 1'b0;
        busy_d        = 1'b0;
        presc_clear_s = (state_d != state_q) &&
                        ((state_d == ST_ON) || (state_d == ST_OFF));
        if (state_d != state_q) begin
            tcnt_d = {TCNT_W{1'b0}};
        end else if (tick_s && in_period_s) begin
            tcnt_d = tcnt_q + TCNT_W'(1);
        end else begin
            tcnt_d = tcnt_q;
        end
        out_d  = (state_d == ST_ON);
        busy_d = (state_d == ST_ON) || (state_d == ST_OFF);
    end

    // State, counters and output registers; reset abandons any period and
    // discards queued events.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            tcnt_q    <= {TCNT_W{1'b0}};
            pending_q <= {PEND_W{1'b0}};
            out_q     <= 1'b0;
            busy_q    <= 1'b0;
            dropped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tcnt_q    <= tcnt_d;
            pending_q <= pending_d;
            out_q     <= out_d;
            busy_q    <= busy_d;
            dropped_q <= dropped_d;
        end
    end

    assign bus.out     = out_q;
    assign bus.busy    = busy_q;
    assign bus.pending = pending_q;
    assign bus.dropped = dropped_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Testbench for pulse_stretcher: directed scenarios with literal timing
// expectations plus randomized events and resets, all checked every cycle
// against a cycle-countdown reference model of the output periods.
module tb_pulse_stretcher;

    localparam int N         = 2;
    localparam int ON_TICKS  = 3;
    localparam int OFF_TICKS = 2;
    localparam int PEND_W    = 2;
    localparam int PER       = 1 << N;
    localparam int PMAX      = (1 << PEND_W) - 1;
    localparam int HN        = 256;

    logic clk;
    logic rst;

    pulse_stretcher_if #(.PEND_W(PEND_W)) ifc ();

    pulse_stretcher #(
        .N         (N),
        .ON_TICKS  (ON_TICKS),
        .OFF_TICKS (OFF_TICKS),
        .PEND_W    (PEND_W)
    ) dut (
        .clock (clk),
        .reset (rst),
        .bus   (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total;
    int bad;
    bit chk_en;

    // Reference model: phase 0=idle 1=high 2=low gap, cycles left in phase
    int m_st;
    int m_left;
    int m_pend;
    bit m_drop;

    // Per-test history, index 0 = first cycle after the first driven edge
    bit h_out   [HN];
    bit h_busy  [HN];
    bit h_drop  [HN];
    int h_pend  [HN];
    bit h_mout  [HN];
    bit h_mbusy [HN];

    // Advance the reference model at each clock edge from the sampled inputs.
    always @(posedge clk) begin
        bit fin;
        bit dec;
        bit inc;
        int old_pend;
        if (rst) begin
            m_st   = 0;
            m_left = 0;
            m_pend = 0;
            m_drop = 1'b0;
        end else begin
            fin      = (m_st != 0) && (m_left == 1);
            dec      = ((m_st == 2) && fin && (m_pend > 0)) || ((m_st == 0) && (m_pend > 0));
            inc      = ifc.evt && ((m_st != 0) || (m_pend > 0));
            old_pend = m_pend;
            m_drop   = 1'b0;
            if (inc && !dec) begin
                if (m_pend == PMAX) m_drop = 1'b1;
                else m_pend = m_pend + 1;
            end else if (dec && !inc) begin
                m_pend = m_pend - 1;
            end
            if (m_st == 0) begin
                if (ifc.evt || old_pend > 0) begin
                    m_st = 1;
                    m_left = ON_TICKS * PER;
                end
            end else if (m_st == 1) begin
                if (fin) begin
                    m_st = 2;
                    m_left = OFF_TICKS * PER;
                end else begin
                    m_left = m_left - 1;
                end
            end else begin
                if (fin) begin
                    if (old_pend > 0) begin
                        m_st = 1;
                        m_left = ON_TICKS * PER;
                    end else begin
                        m_st = 0;
                    end
                end else begin
                    m_left = m_left - 1;
                end
            end
        end
    end

    // Compare every DUT output against the model away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            total = total + 4;
            if (ifc.out !== (m_st == 1)) begin
                bad = bad + 1;
                $display("FAIL cyc_out t=%0t: got %b expected %b", $time, ifc.out, (m_st == 1));
            end
            if (ifc.busy !== (m_st != 0)) begin
                bad = bad + 1;
                $display("FAIL cyc_busy t=%0t: got %b expected %b", $time, ifc.busy, (m_st != 0));
            end
            if (int'(ifc.pending) != m_pend) begin
                bad = bad + 1;
                $display("FAIL cyc_pending t=%0t: got %0d expected %0d", $time, ifc.pending, m_pend);
            end
            if (ifc.dropped !== m_drop) begin
                bad = bad + 1;
                $display("FAIL cyc_dropped t=%0t: got %b expected %b", $time, ifc.dropped, m_drop);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total = total + 1;
        if (act != exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs (called at a negedge) and return at the next negedge.
    task automatic tick(input logic e, input logic r);
        ifc.evt = e;
        rst = r;
        @(negedge clk);
    endtask

    task automatic rec(input int idx, input logic e, input logic r);
        tick(e, r);
        h_out[idx]   = ifc.out;
        h_busy[idx]  = ifc.busy;
        h_drop[idx]  = ifc.dropped;
        h_pend[idx]  = int'(ifc.pending);
        h_mout[idx]  = (m_st == 1);
        h_mbusy[idx] = (m_st != 0);
    endtask

    task automatic idle_gap(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0);
    endtask

    function automatic int cnt_out(input int lo, input int hi);
        int c = 0;
        for (int i = lo; i <= hi; i++) if (h_out[i]) c++;
        return c;
    endfunction

    function automatic int cnt_busy(input int lo, input int hi);
        int c = 0;
        for (int i = lo; i <= hi; i++) if (h_busy[i]) c++;
        return c;
    endfunction

    function automatic int cnt_drop(input int lo, input int hi);
        int c = 0;
        for (int i = lo; i <= hi; i++) if (h_drop[i]) c++;
        return c;
    endfunction

    function automatic int max_pend(input int lo, input int hi);
        int m = 0;
        for (int i = lo; i <= hi; i++) if (h_pend[i] > m) m = h_pend[i];
        return m;
    endfunction

    function automatic int rises(input int lo, input int hi);
        int c = 0;
        for (int i = lo; i <= hi; i++) if (h_out[i] && (i == lo || !h_out[i-1])) c++;
        return c;
    endfunction

    initial begin
        total  = 0;
        bad    = 0;
        chk_en = 1'b0;
        rst    = 1'b1;
        ifc.evt = 1'b0;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        chk("reset_out", int'(ifc.out), 0);
        chk("reset_busy", int'(ifc.busy), 0);
        chk("reset_pending", int'(ifc.pending), 0);
        chk("reset_dropped", int'(ifc.dropped), 0);
        idle_gap(7);

        // 1: single event -> 12 high, 8 low-busy, then idle
        rec(0, 1'b1, 1'b0);
        for (int i = 1; i < 30; i++) rec(i, 1'b0, 1'b0);
        chk("t1_high_first", int'(h_out[0]), 1);
        chk("t1_high_len", cnt_out(0, 11), 12);
        chk("t1_high_total", cnt_out(0, 29), 12);
        chk("t1_low_busy", cnt_busy(12, 19), 8);
        chk("t1_idle_at_20", int'(h_busy[20]), 0);
        chk("t1_model_hi11", int'(h_mout[11]), 1);
        chk("t1_model_lo12", int'(h_mout[12]), 0);
        chk("t1_model_busy19", int'(h_mbusy[19]), 1);
        chk("t1_model_idle20", int'(h_mbusy[20]), 0);
        idle_gap(5);

        // 2: three events two cycles apart -> three periods back to back
        rec(0, 1'b1, 1'b0);
        rec(1, 1'b0, 1'b0);
        rec(2, 1'b1, 1'b0);
        rec(3, 1'b0, 1'b0);
        rec(4, 1'b1, 1'b0);
        for (int i = 5; i < 75; i++) rec(i, 1'b0, 1'b0);
        chk("t2_pend_peak", max_pend(0, 74), 2);
        chk("t2_rises", rises(0, 74), 3);
        chk("t2_high_cycles", cnt_out(0, 74), 36);
        chk("t2_busy_run", cnt_busy(0, 59), 60);
        chk("t2_idle_at_60", int'(h_busy[60]), 0);
        chk("t2_second_high", int'(h_out[20]), 1);
        chk("t2_pend_at_20", h_pend[20], 1);
        chk("t2_pend_at_40", h_pend[40], 0);
        idle_gap(5);

        // 3: nine events on consecutive cycles -> saturate at 3, 5 drops, 4 highs
        for (int i = 0; i < 9; i++) rec(i, 1'b1, 1'b0);
        for (int i = 9; i < 110; i++) rec(i, 1'b0, 1'b0);
        chk("t3_pend_peak", max_pend(0, 109), 3);
        chk("t3_drops", cnt_drop(0, 109), 5);
        chk("t3_rises", rises(0, 109), 4);
        chk("t3_busy_run", cnt_busy(0, 79), 80);
        chk("t3_idle_at_80", int'(h_busy[80]), 0);
        idle_gap(5);

        // 4: event on final OFF tick while pending=1 -> pending stays 1, ON next cycle
        rec(0, 1'b1, 1'b0);
        rec(1, 1'b1, 1'b0);
        for (int i = 2; i < 20; i++) rec(i, 1'b0, 1'b0);
        rec(20, 1'b1, 1'b0);
        for (int i = 21; i < 70; i++) rec(i, 1'b0, 1'b0);
        chk("t4_pend_before", h_pend[19], 1);
        chk("t4_low_before", int'(h_out[19]), 0);
        chk("t4_pend_kept", h_pend[20], 1);
        chk("t4_on_next", int'(h_out[20]), 1);
        chk("t4_drop", int'(h_drop[20]), 0);
        chk("t4_rises", rises(0, 69), 3);
        idle_gap(5);

        // 5: event on final OFF tick while pending=0 -> one idle cycle, then ON
        rec(0, 1'b1, 1'b0);
        for (int i = 1; i < 20; i++) rec(i, 1'b0, 1'b0);
        rec(20, 1'b1, 1'b0);
        for (int i = 21; i < 50; i++) rec(i, 1'b0, 1'b0);
        chk("t5_idle_busy", int'(h_busy[20]), 0);
        chk("t5_idle_out", int'(h_out[20]), 0);
        chk("t5_pend_one", h_pend[20], 1);
        chk("t5_out_rise", int'(h_out[21]), 1);
        chk("t5_pend_zero", h_pend[21], 0);
        idle_gap(5);

        // 6: reset mid-ON with pending=2 -> everything zero, no replay
        rec(0, 1'b1, 1'b0);
        rec(1, 1'b1, 1'b0);
        rec(2, 1'b1, 1'b0);
        rec(3, 1'b0, 1'b0);
        rec(4, 1'b0, 1'b0);
        rec(5, 1'b0, 1'b1);
        for (int i = 6; i < 66; i++) rec(i, 1'b0, 1'b0);
        chk("t6_pend_before", h_pend[4], 2);
        chk("t6_out_zero", int'(h_out[5]), 0);
        chk("t6_busy_zero", int'(h_busy[5]), 0);
        chk("t6_pend_zero", h_pend[5], 0);
        chk("t6_drop_zero", int'(h_drop[5]), 0);
        chk("t6_no_highs", cnt_out(5, 65), 0);
        chk("t6_no_busy", cnt_busy(5, 65), 0);

        // Randomized events, bursts and occasional resets
        for (int i = 0; i < 4000; i++) begin
            logic e;
            logic r;
            if ((i / 200) % 2 == 1) e = ($urandom_range(0, 1) == 0);
            else e = ($urandom_range(0, 9) == 0);
            r = ($urandom_range(0, 499) == 0);
            tick(e, r);
        end
        tick(1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pulse_stretcher.md
# pulse_stretcher

Output-side counterpart to the team's input debouncer. It turns single-cycle event pulses from the game/interface logic into clean, human-visible output levels, such as LEDs or a buzzer enable. Each level has a guaranteed minimum high time and a minimum low gap, both timed by a tick prescaler. Events that arrive while the output is busy are counted and replayed in order, so no event is silently merged.

## Interface
Parameters:
- N, 17, prescaler width; one tick every 2^N clock cycles.
- ON_TICKS, 3, high-time length in ticks; must be ≥ 1.
- OFF_TICKS, 3, minimum low gap in ticks; must be ≥ 1.
- PEND_W, 3, pending-counter width; max pending is 2^PEND_W − 1.

Ports:
- clock  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- event  in  1  one-cycle request pulse; sampled every clock.
- out  out  1  stretched output level (registered).
- busy  out  1  high in ON or OFF state.
- pending  out  PEND_W  queued events not yet started.
- dropped  out  1  one-cycle pulse when an event is lost to saturation.

## Operation
- States: IDLE, ON, OFF. Encoding is IDLE=2'b00, ON=2'b01, OFF=2'b10; 2'b11 recovers to IDLE.
- Prescaler `presc` is N bits. It increments every cycle and is cleared to 0 on every transition into ON or OFF. `tick = &presc`.
- Tick counter `tcnt` counts ticks within the current state and is cleared on state entry.
- IDLE:
  - event=1 → ON.
  - out=0, busy=0.
- ON:
  - out=1, busy=1.
  - On the tick where `tcnt == ON_TICKS-1` → OFF.
- OFF:
  - out=0, busy=1.
  - On the tick where `tcnt == OFF_TICKS-1`:
    - if `pending > 0`, decrement pending and go → ON;
    - otherwise → IDLE.
- Event while in ON or OFF:
  - pending increments by 1, saturating.
  - If pending is at max and no decrement occurs that cycle, pending is unchanged and dropped=1 for that cycle.
- Event in the same cycle as a decrement (OFF→ON with pending > 0): net pending is unchanged and dropped=0.
- Event in the same cycle as OFF→IDLE: the event is queued (pending becomes 1). The next cycle, IDLE sees pending > 0, decrements it, and enters ON.
- IDLE with pending > 0 → ON with decrement. This is reachable only via the case above.
- Width rules:
  - tcnt is sized to hold max(ON_TICKS, OFF_TICKS) − 1.
  - pending arithmetic never wraps.

## Timing
- Reset values: state=IDLE, presc=0, tcnt=0, pending=0, out=0, busy=0, dropped=0. Reset takes effect on the next clock edge and overrides any in-flight ON or OFF period. No event is replayed after reset.
- Latency: event sampled at edge k in IDLE → out=1 and busy=1 from cycle k+1.
- ON duration is exactly ON_TICKS·2^N cycles; OFF duration is exactly OFF_TICKS·2^N cycles.
- Back-to-back queued events produce a period of (ON_TICKS+OFF_TICKS)·2^N cycles with no extra idle cycle.
- dropped is a one-cycle pulse aligned to the cycle after the offending event is sampled.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Package `stretch_pkg`: state localparams (IDLE, ON, OFF) and the 2-bit state type.
- Sub-module `tick_prescaler` (params N; ports clock, reset, clear, tick). It contains the free-running counter with synchronous clear and `tick = &count`.
- Top-level contents: FSM, tcnt, pending counter, output registers.

## Test plan
1. N=2, ON_TICKS=3, OFF_TICKS=2. Single event at cycle 10 → out high for cycles 11–22 (12 cycles), then low with busy=1 for 8 cycles, then busy=0 at cycle 31.
2. Same configuration, three events spaced 2 cycles apart starting at cycle 10 → pending reaches 2, then counts down. Out shows three 12-cycle highs separated by 8-cycle lows with no idle gap.
3. PEND_W=2, nine events one per cycle during ON → pending saturates at 3, dropped pulses exactly 5 times, and exactly 4 high periods are emitted.
4. Event coinciding with the final OFF tick while pending=1 → pending stays at 1 and the next ON starts on the following cycle.
5. Event coinciding with the final OFF tick while pending=0 → one IDLE cycle, pending goes 1 then 0, and out rises 2 cycles after the event.
6. Assert reset mid-ON with pending=2 → all outputs are zero the next cycle. No further highs appear until a new event arrives.
